// File: rtl/rom_loader.sv
// rom_loader: framed byte-stream boot loader feeding the instruction ROM write port.
// Latency: w_en_o pulses in the cycle after the 4th byte of each word is accepted.
// Backpressure: rx_ready_o low during the WRITE cycle and permanently in ERR; rx_valid_i low just stalls.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int unsigned ROM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        w_en_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic [3:0]  w_sel_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;
  localparam state_t EndOfData = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
  localparam state_t EndOfData = S_DONE;
`endif

  // 17 bits so a depth of 65536 still compares correctly against a 16-bit length.
  localparam logic [16:0] DepthLim = 17'(ROM_DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] pack_q, pack_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        rx_ready_q;
  logic        w_en_q;
  logic [31:0] w_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_sel_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic        accept;
  logic [15:0] len_full;

  assign accept   = rx_valid_i & rx_ready_q;
  assign len_full = {rx_data_i, len_q[7:0]};

  // Next-state and datapath update for the frame parser.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept && (rx_data_i == SYNC_BYTE)) begin
          state_d    = S_LEN0;
          word_cnt_d = 16'd0;
          byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data_i;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = rx_data_i;
          if ({1'b0, len_full} > DepthLim) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = EndOfData;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          // Shifting in from the top leaves byte 0 in [7:0] after four bytes.
          pack_d     = {rx_data_i, pack_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q + rx_data_i;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = (word_cnt_q == (len_q - 16'd1)) ? EndOfData : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        // ERR is sticky until reset.
        state_d = state_q;
      end
    endcase
  end

  // State, counters and outputs registered from the next state so outputs are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      word_cnt_q <= 16'd0;
      byte_cnt_q <= 2'd0;
      pack_q     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
      rx_ready_q <= 1'b0;
      w_en_q     <= 1'b0;
      w_addr_q   <= 32'd0;
      w_data_q   <= 32'd0;
      w_sel_q    <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
      rx_ready_q <= (state_d != S_WRITE) && (state_d != S_ERR);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      w_en_q     <= (state_d == S_WRITE);
      w_sel_q    <= (state_d == S_WRITE) ? 4'hF : 4'h0;
      // Address uses the pre-increment word count; word_cnt advances during WRITE.
      if (state_d == S_WRITE) begin
        w_addr_q <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
        w_data_q <= pack_d;
      end
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign w_en_o     = w_en_q;
  assign w_addr_o   = w_addr_q;
  assign w_data_o   = w_data_q;
  assign w_sel_o    = w_sel_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: random and directed frames, scoreboard of expected ROM writes.
// Reference model: word k of a frame lands at BASE + 4k; the frame ends in done unless rejected.
// Build with LOADER_CHECKSUM_EN defined to exercise the trailing checksum byte.
module tb_rom_loader;

  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Base  = 32'h0000_0000;
  localparam logic [7:0]  Sync  = 8'hA5;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CsumOn = 1'b1;
`else
  localparam bit CsumOn = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready_o;
  logic        w_en_o;
  logic [31:0] w_addr_o;
  logic [31:0] w_data_o;
  logic [3:0]  w_sel_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int          total = 0;
  int          bad = 0;
  wr_t         exp_q[$];
  logic [31:0] frame_words[$];

  always #5 clk = ~clk;

  rom_loader #(.ROM_DEPTH(Depth), .BASE_ADDR(Base), .SYNC_BYTE(Sync)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready_o),
    .w_en_o(w_en_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o), .w_sel_o(w_sel_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n && w_en_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                 w_addr_o, w_data_o);
      end else begin
        e = exp_q.pop_front();
        check("w_addr", w_addr_o, e.addr);
        check("w_data", w_data_o, e.data);
        check("w_sel", {28'd0, w_sel_o}, 32'h0000_000F);
        check("ready_in_write", {31'd0, rx_ready_o}, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (n) @(negedge clk);
  endtask

  // Offer one byte from a negedge; returns on the negedge after it was taken.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = rx_ready_o;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte 0x%02h not taken, expected acceptance within 100 cycles", b);
    end
  endtask

  function automatic logic [7:0] frame_sum();
    logic [7:0] s;
    s = 8'd0;
    foreach (frame_words[k]) begin
      s = s + frame_words[k][7:0] + frame_words[k][15:8] + frame_words[k][23:16] + frame_words[k][31:24];
    end
    return s;
  endfunction

  // Data bytes plus optional checksum; expectations are queued as the words are issued.
  task automatic send_body(input bit gaps, input bit with_csum, input logic [7:0] csum_byte);
    wr_t e;
    logic [31:0] w;
    foreach (frame_words[k]) begin
      w      = frame_words[k];
      e.addr = Base + 32'(k) * 32'd4;
      e.data = w;
      exp_q.push_back(e);
      for (int j = 0; j < 4; j++) begin
        if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
        send_byte(w[8*j +: 8]);
      end
    end
    if (with_csum) send_byte(csum_byte);
  endtask

  task automatic send_frame(input bit gaps, input bit with_csum, input logic [7:0] csum_byte);
    int n;
    n = frame_words.size();
    send_byte(Sync);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    send_body(gaps, with_csum, csum_byte);
  endtask

  task automatic wait_status(input string name, input bit exp_done, input bit exp_err);
    int i;
    i = 0;
    while (!done_o && !err_o && i < 50) begin
      @(negedge clk);
      i++;
    end
    check({name, "_done"}, {31'd0, done_o}, {31'd0, exp_done});
    check({name, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check({name, "_flags"}, {27'd0, rx_ready_o, w_en_o, busy_o, done_o, err_o}, 32'd0);
    check({name, "_addr"}, w_addr_o, 32'd0);
    check({name, "_data"}, w_data_o, 32'd0);
    check({name, "_sel"}, {28'd0, w_sel_o}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({name, "_idle_ready"}, {31'd0, rx_ready_o}, 32'd1);
  endtask

  initial begin
    int n;
    bit corrupt;
    logic [7:0] g;

    do_reset("reset0");

    // Two-word frame from byte 78 56 34 12 EF BE AD DE.
    frame_words = '{32'h1234_5678, 32'hDEAD_BEEF};
    send_frame(1'b0, CsumOn, frame_sum());
    wait_status("frame_a", 1'b1, 1'b0);

    // Back-to-back frame straight out of DONE.
    frame_words = '{32'hDDCC_BBAA};
    send_byte(Sync);
    check("b2b_done_cleared", {31'd0, done_o}, 32'd0);
    check("b2b_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_body(1'b0, CsumOn, frame_sum());
    wait_status("b2b", 1'b1, 1'b0);

    // Garbage bytes before a sync in IDLE are discarded.
    do_reset("reset1");
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    frame_words = '{32'h0403_0201};
    send_frame(1'b0, CsumOn, frame_sum());
    wait_status("garbage", 1'b1, 1'b0);

    // Wrong checksum: write still happens, then err when checksum is enabled.
    frame_words = '{32'h0403_0201};
    send_frame(1'b0, CsumOn, 8'h0B);
    wait_status("csum_bad", !CsumOn, CsumOn);

    // Oversize length 1025 is rejected, nothing is accepted afterwards.
    do_reset("reset2");
    send_byte(Sync);
    send_byte(8'h01);
    send_byte(8'h04);
    wait_status("len_over", 1'b0, 1'b1);
    check("len_over_ready", {31'd0, rx_ready_o}, 32'd0);
    rx_valid = 1'b1;
    rx_data  = Sync;
    repeat (20) @(negedge clk);
    rx_valid = 1'b0;
    check("err_sticky", {30'd0, err_o, rx_ready_o}, 32'd2);

    // Zero-length frame completes with no writes.
    do_reset("reset3");
    frame_words.delete();
    send_frame(1'b0, CsumOn, frame_sum());
    wait_status("len_zero", 1'b1, 1'b0);

    // Length exactly ROM_DEPTH is accepted.
    frame_words.delete();
    for (int k = 0; k < int'(Depth); k++) frame_words.push_back($urandom);
    send_frame(1'b0, CsumOn, frame_sum());
    wait_status("len_max", 1'b1, 1'b0);

    // Ten-cycle stall between data bytes.
    frame_words = '{32'h4433_2211};
    send_byte(Sync);
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back('{addr: Base, data: 32'h4433_2211});
    send_byte(8'h11);
    send_byte(8'h22);
    idle(10);
    check("stall_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'h33);
    send_byte(8'h44);
    if (CsumOn) send_byte(frame_sum());
    wait_status("stall", 1'b1, 1'b0);

    // Reset mid-word: the partial word is never written.
    send_byte(Sync);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h66);
    idle(10);
    send_byte(8'h77);
    do_reset("reset_mid");
    frame_words = '{32'hCAFE_F00D};
    send_frame(1'b0, CsumOn, frame_sum());
    wait_status("after_mid_reset", 1'b1, 1'b0);

    // Random frames with leading garbage and random gaps.
    for (int it = 0; it < 15; it++) begin
      n = $urandom_range(0, 6);
      for (int k = 0; k < $urandom_range(0, 3); k++) begin
        g = 8'($urandom);
        if (g == Sync) g = 8'h00;
        send_byte(g);
      end
      frame_words.delete();
      for (int k = 0; k < n; k++) frame_words.push_back($urandom);
      corrupt = CsumOn && ($urandom_range(0, 3) == 0);
      send_frame(1'b1, CsumOn, frame_sum() ^ {7'd0, corrupt});
      wait_status("random", !corrupt, corrupt);
      if (corrupt) do_reset("reset_rand");
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
